// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring shift-subtract divider for DIV/DIVU
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic             r_signed;
    logic             r_neg1;
    logic             r_neg2;

    logic             w_go;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_remf;

    assign w_go        = start_i && !annul_i;
    assign w_iter_done = (r_cnt == CW'(WIDTH));
    assign w_abs1      = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2      = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // The shifted partial remainder needs one extra bit; once the divisor is
    // subtracted the result always fits back into WIDTH bits.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

    assign w_quot = (r_signed && (r_neg1 ^ r_neg2)) ? -r_dvd : r_dvd;
    assign w_remf = (r_signed && r_neg1) ? -r_rem : r_rem;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FREE: begin
                if (w_go) begin
                    if (opdata2_i == '0) w_state_nxt = S_BYZERO;
                    else                 w_state_nxt = S_ON;
                end
            end
            S_BYZERO: begin
                if (!w_go) w_state_nxt = S_FREE;
                else       w_state_nxt = S_END;
            end
            S_ON: begin
                if (!w_go)            w_state_nxt = S_FREE;
                else if (w_iter_done) w_state_nxt = S_END;
            end
            S_END: begin
                if (!w_go) w_state_nxt = S_FREE;
            end
            default: w_state_nxt = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_signed <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_FREE && w_go && opdata2_i != '0) begin
                r_rem    <= '0;
                r_dvd    <= w_abs1;
                r_dvs    <= w_abs2;
                r_signed <= signed_div_i;
                r_neg1   <= opdata1_i[WIDTH-1];
                r_neg2   <= opdata2_i[WIDTH-1];
                r_cnt    <= '0;
            end else if (r_state == S_ON && w_go && !w_iter_done) begin
                r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                r_cnt <= r_cnt + CW'(1);
            end

            // Result is captured once on entry to END and held there.
            if (w_state_nxt == S_END) begin
                if (r_state != S_END) begin
                    ready_o  <= 1'b1;
                    result_o <= (r_state == S_BYZERO) ? '0 : {w_remf, w_quot};
                end
            end else begin
                ready_o  <= 1'b0;
                result_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation at the next edge (T), scrambles the operand inputs
    // right after acceptance, waits for ready_o, holds, then drops start_i.
    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold,
                          output int lat, output logic [63:0] res, output logic rdy_hold,
                          output logic [63:0] res_hold, output logic rdy_after, output logic [63:0] res_after);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb_q.push_back(model(s, a, b));
        step();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
        lat = 0;
        while (!ready_o && lat < 100) begin
            step();
            lat++;
        end
        res = result_o;
        repeat (hold) step();
        rdy_hold = ready_o;
        res_hold = result_o;
        start_i = 1'b0;
        step();
        rdy_after = ready_o;
        res_after = result_o;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'd50; opdata2_i = 32'd0;
        step(); step();
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        n_checks++;
        if (result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_o); end
        start_i = 1'b0; rst = 1'b0;
        step();
    endtask

    task automatic test_unsigned_basic();
        int lat; logic [63:0] res, res_h, res_a, exp; logic rdy_h, rdy_a;
        run_op(1'b0, 32'd100, 32'd7, 3, lat, res, rdy_h, res_h, rdy_a, res_a);
        exp = sb_q.pop_front();
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
        n_checks++;
        if (res !== exp) begin n_fail++; $display("FAIL u100_7_result: got %h want %h", res, exp); end
        n_checks++;
        if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL u100_7_const: got %h want %h", res, {32'd2, 32'd14}); end
        n_checks++;
        if (rdy_h !== 1'b1 || res_h !== exp) begin n_fail++; $display("FAIL end_hold: got %b/%h want 1/%h", rdy_h, res_h, exp); end
        n_checks++;
        if (rdy_a !== 1'b0 || res_a !== 64'd0) begin n_fail++; $display("FAIL end_release: got %b/%h want 0/0", rdy_a, res_a); end
    endtask

    task automatic test_signed_corners();
        bit          ts[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ta[4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] tb[4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1};
        logic [63:0] tc[4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h1, 32'hFFFFFFFD},
                               {32'h0, 32'h80000000}, {32'h0, 32'hFFFFFFFF}};
        for (int i = 0; i < 4; i++) begin
            int lat; logic [63:0] res, res_h, res_a, exp; logic rdy_h, rdy_a;
            run_op(ts[i], ta[i], tb[i], 0, lat, res, rdy_h, res_h, rdy_a, res_a);
            exp = sb_q.pop_front();
            n_checks++;
            if (res !== exp || res !== tc[i]) begin
                n_fail++;
                $display("FAIL corner_%0d: got %h want %h (model %h)", i, res, tc[i], exp);
            end
            n_checks++;
            if (lat !== 33) begin n_fail++; $display("FAIL corner_%0d_latency: got %0d want 33", i, lat); end
        end
    endtask

    task automatic test_div_zero();
        for (int s = 0; s < 2; s++) begin
            int lat; logic [63:0] res, res_h, res_a, exp; logic rdy_h, rdy_a;
            run_op(s[0], 32'h1234, 32'd0, 1, lat, res, rdy_h, res_h, rdy_a, res_a);
            exp = sb_q.pop_front();
            n_checks++;
            if (lat !== 1) begin n_fail++; $display("FAIL divzero_%0d_latency: got %0d want 1", s, lat); end
            n_checks++;
            if (res !== exp || rdy_h !== 1'b1) begin n_fail++; $display("FAIL divzero_%0d_result: got %b/%h want 1/%h", s, rdy_h, res, exp); end
            n_checks++;
            if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL divzero_%0d_release: got %b want 0", s, rdy_a); end
        end
    endtask

    // kind: 0 = annul_i at T+10, 1 = rst at T+10, 2 = start_i dropped at T+5
    task automatic test_abort(input int kind);
        int rises = 0; int lat; logic [63:0] res, res_h, res_a, exp; logic rdy_h, rdy_a;
        int at = (kind == 2) ? 5 : 10;
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        step();
        for (int i = 1; i < at; i++) begin
            if (ready_o) rises++;
            step();
        end
        if (kind == 0) annul_i = 1'b1;
        else if (kind == 1) rst = 1'b1;
        else start_i = 1'b0;
        step();
        annul_i = 1'b0; rst = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) rises++;
            step();
        end
        n_checks++;
        if (rises !== 0) begin n_fail++; $display("FAIL abort_%0d_no_ready: got %0d rises want 0", kind, rises); end
        run_op(1'b0, 32'd9, 32'd3, 0, lat, res, rdy_h, res_h, rdy_a, res_a);
        exp = sb_q.pop_front();
        n_checks++;
        if (lat !== 33 || res !== exp || res !== {32'd0, 32'd3}) begin
            n_fail++;
            $display("FAIL abort_%0d_restart: got lat %0d res %h want lat 33 res %h", kind, lat, res, exp);
        end
    endtask

    task automatic test_random_back_to_back();
        for (int i = 0; i < 40; i++) begin
            int lat; logic [63:0] res, res_h, res_a, exp; logic rdy_h, rdy_a;
            bit s; logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = -32'($urandom_range(1, 9));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(s, a, b, 0, lat, res, rdy_h, res_h, rdy_a, res_a);
            exp = sb_q.pop_front();
            n_checks++;
            if (res !== exp || lat !== ((b == 32'd0) ? 1 : 33) || rdy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL random_%0d: s=%0d a=%h b=%h got %h lat %0d want %h", i, s, a, b, res, lat, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        test_reset();
        test_unsigned_basic();
        test_signed_corners();
        test_div_zero();
        test_abort(0);
        test_abort(1);
        test_abort(2);
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider attached to the execute stage; serves DIV/DIVU.
- Computes quotient and remainder one bit per cycle (restoring shift-subtract).
- While a division is in flight, the execute stage derives its stall request (stallreq_from_ex) from ready_o being low. That request freezes PC, IF, ID and EX (stall = 6'b001111) until ready_o rises.
- Result is written back to HI/LO by the execute stage.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH, iteration count is WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high (RstEnable = 1)
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; held high by EX for the whole operation
- annul_i  in  1  abort (e.g. exception/flush); overrides start_i
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
- ready_o  out  1  result valid

Behaviour:
- All state and outputs are registered. rst high at an edge gives:
  - state = FREE, counter = 0
  - result_o = 0, ready_o = 0
  - Applies mid-operation too; any in-flight division is discarded.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0 at edge T:
    - opdata2_i == 0: go to BYZERO.
    - Otherwise go to ON. Latch |op1| and |op2| (absolute value only when signed_div_i=1 and the operand MSB=1). Also latch signed_div_i and both operand sign bits. counter = 0.
  - Otherwise stay in FREE; ready_o = 0, result_o = 0.
- BYZERO: at the next edge, go to END with result_o = 0 and ready_o = 1. No exception is raised.
- ON (counter < WIDTH), each edge performs one iteration:
  - Shift {partial_rem, dividend} left by 1.
  - Trial-subtract the divisor from the partial remainder.
  - If the result is non-negative, keep the difference and set quotient bit = 1; else quotient bit = 0.
  - counter += 1.
- ON (counter == WIDTH): at the next edge, go to END with the fix-up applied:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend was negative.
  - result_o and ready_o = 1 are registered at this edge.
- Latency: a start sampled at edge T gives ready_o = 1 after edge T+WIDTH+1 (T+33 for 32 bits). Divide-by-zero gives ready_o = 1 after edge T+1.
- Operand inputs are ignored after the start is accepted; only the latched copies are used.
- END:
  - Holds result_o and ready_o = 1 while start_i stays high.
  - At the first edge with start_i = 0: go to FREE, ready_o = 0, result_o = 0.
- Abort: in BYZERO or ON, annul_i = 1 or start_i = 0 at an edge gives FREE, ready_o = 0, result_o = 0. No result is ever presented.
- annul_i = 1 in END also forces FREE.
- Corner cases:
  - Overflow case -2^31 / -1 (signed): quotient = 0x80000000 (wraps), remainder = 0.
  - Unsigned operands with MSB set are treated as full 32-bit magnitudes.
- Back-to-back: a new start is accepted only from FREE, i.e. at least one cycle with start_i = 0 separates operations.

Test Plan:
- Unsigned 100 / 7, start at edge T and held:
  - ready_o = 0 through T+32.
  - ready_o = 1 after T+33 with result_o = {32'd2, 32'd14}.
  - Deassert start_i: ready_o = 0 and result_o = 0 at the next edge.
- Signed -7 / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2: quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (0x1234 / 0), signed and unsigned: ready_o = 1 after T+1, result_o = 0; no hang.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at T+10 (and separately rst at T+10): ready_o never rises; FREE at the next edge. A new start of 9/3 then yields {0, 3} after a further 33 edges.
- start_i dropped mid-ON at T+5 aborts the operation. Random signed/unsigned operands are checked against a reference model of the quotient/remainder rules above, with start held throughout.
